// File: rtl/bmp_blit_mm.sv
// bmp_blit_mm: memory-mapped blitter copying ROM images into video memory
module bmp_blit_mm #(
  parameter int PIX_W = 6,
  parameter int SCR_W = 640,
  parameter int SCR_H = 480,
  parameter int N_IMG = 4,
  parameter int IMG_AW = 16,
  parameter logic [15:0] BASE = 16'hC008,
  localparam int SW = (N_IMG > 1) ? $clog2(N_IMG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       mm_addr,
  input  logic              mm_we,
  input  logic              mm_re,
  input  logic [15:0]       mm_wdata,
  output logic [15:0]       mm_rdata,
  output logic [SW-1:0]     img_sel,
  output logic [IMG_AW-1:0] img_addr,
  input  logic [PIX_W-1:0]  img_rdata,
  output logic [18:0]       waddr,
  output logic [PIX_W-1:0]  wdata,
  output logic              we
);
  localparam int DW = 2 * PIX_W;
  localparam int XW = (DW > 10 ? DW : 10) + 1;
  localparam int YW = (DW > 9 ? DW : 9) + 1;
  localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, RUN = 2'd2;
  logic [1:0] state, op_mode;
  logic [9:0] xloc, op_x;
  logic [8:0] yloc, op_y;
  logic key_en, op_ken, pv, clip, last, dropped, bad_idx, busy;
  logic [PIX_W-1:0] key, op_key, fill, op_fill;
  logic [DW-1:0] width, height, i, j, h_new;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic ctl_wr, idx_bad, start, stat_rd, row_end, end_px, transparent;
  // Decode of bus accesses and per-pixel datapath
  always_comb begin
    busy = state != IDLE;
    ctl_wr = mm_we && mm_addr == BASE;
    idx_bad = int'(mm_wdata[13:0]) >= N_IMG;
    start = ctl_wr && mm_wdata[15:14] != 2'b00 && !busy && !idx_bad;
    stat_rd = mm_re && mm_addr == BASE + 16'd5;
    h_new = {height[DW-1:PIX_W], img_rdata};
    xs = XW'(op_x) + XW'(i);
    ys = YW'(op_y) + YW'(j);
    row_end = i == width - DW'(1);
    end_px = row_end && j == height - DW'(1);
    transparent = op_ken && img_rdata == op_key;
    we = pv && !clip && (op_mode == 2'b11 || !transparent);
    wdata = !pv ? '0 : op_mode == 2'b11 ? op_fill : op_mode == 2'b10 ? '0 : img_rdata;
    mm_rdata = stat_rd ? {13'b0, bad_idx, dropped, busy} : 16'h0;
  end
  // Register file, sticky status and the IDLE/HDR/RUN sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_mode <= 2'b00;
      xloc <= '0;
      yloc <= '0;
      key_en <= 1'b0;
      key <= '0;
      fill <= '0;
      op_x <= '0;
      op_y <= '0;
      op_ken <= 1'b0;
      op_key <= '0;
      op_fill <= '0;
      width <= '0;
      height <= '0;
      i <= '0;
      j <= '0;
      pv <= 1'b0;
      clip <= 1'b0;
      last <= 1'b0;
      dropped <= 1'b0;
      bad_idx <= 1'b0;
      img_sel <= '0;
      img_addr <= '0;
      waddr <= '0;
    end else begin
      if (mm_we && mm_addr == BASE + 16'd1) xloc <= mm_wdata[9:0];
      if (mm_we && mm_addr == BASE + 16'd2) yloc <= mm_wdata[8:0];
      if (mm_we && mm_addr == BASE + 16'd3) {key_en, key} <= {mm_wdata[15], mm_wdata[PIX_W-1:0]};
      if (mm_we && mm_addr == BASE + 16'd4) fill <= mm_wdata[PIX_W-1:0];
      dropped <= (ctl_wr && mm_wdata[15:14] != 2'b00 && busy) || (dropped && !stat_rd);
      bad_idx <= (ctl_wr && idx_bad) || (bad_idx && !stat_rd);
      pv <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= HDR;
          op_mode <= mm_wdata[15:14];
          img_sel <= SW'(mm_wdata[13:0]);
          img_addr <= '0;
          {op_x, op_y, op_ken, op_key, op_fill} <= {xloc, yloc, key_en, key, fill};
          last <= 1'b0;
        end
        HDR: begin
          img_addr <= img_addr == IMG_AW'(4) ? img_addr : img_addr + IMG_AW'(1);
          if (img_addr == IMG_AW'(1)) width[DW-1:PIX_W] <= img_rdata;
          if (img_addr == IMG_AW'(2)) width[PIX_W-1:0] <= img_rdata;
          if (img_addr == IMG_AW'(3)) height[DW-1:PIX_W] <= img_rdata;
          if (img_addr == IMG_AW'(4)) begin
            height[PIX_W-1:0] <= img_rdata;
            i <= '0;
            j <= '0;
            state <= (width == '0 || h_new == '0) ? IDLE : RUN;
          end
        end
        RUN: if (last) state <= IDLE;
        else begin
          pv <= 1'b1;
          clip <= xs >= XW'(SCR_W) || ys >= YW'(SCR_H);
          waddr <= 19'(19'(ys) * 19'(SCR_W) + 19'(xs));
          img_addr <= img_addr + IMG_AW'(1);
          last <= end_px;
          i <= row_end ? '0 : i + DW'(1);
          j <= row_end ? j + DW'(1) : j;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
